// File: rtl/rr_mux_reg.sv
// rr_mux_reg -- registered N-channel word multiplexer with valid/ready
// handshakes and a built-in arbiter (fixed priority or round-robin).
//
// Parameters:
//   WIDTH     data width of each channel and of the output
//   CHANNELS  number of producer channels (>= 1)
//   ARB_MODE  0 = fixed priority (lowest index wins), 1 = round-robin
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active low
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel word-available flag
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered selected word
//   out_chan   index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word this cycle
module rr_mux_reg #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int ARB_MODE = 1,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNELS*WIDTH-1:0]  in_data,
    input  logic [CHANNELS-1:0]        in_valid,
    output logic [CHANNELS-1:0]        in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [CW-1:0]              out_chan,
    output logic                       out_valid,
    input  logic                       out_ready
);

    logic [WIDTH-1:0]    r_data;
    logic [CW-1:0]       r_chan;
    logic                r_valid;
    logic [CW-1:0]       r_ptr;

    logic                w_load_en;
    logic                w_hi_found;
    logic [CW-1:0]       w_hi_idx;
    logic                w_lo_found;
    logic [CW-1:0]       w_lo_idx;
    logic                w_found;
    logic [CW-1:0]       w_gidx;
    logic [CHANNELS-1:0] w_grant;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_xfer;

    // Register can take a word when empty or being drained this cycle.
    assign w_load_en = !r_valid || out_ready;

    // Round-robin search order is ptr+1 .. CHANNELS-1, then 0 .. ptr.
    // Requests above ptr form the "hi" group, the rest the "lo" group; the
    // lowest index in hi wins, else the lowest index in lo. Scanning
    // downward lets the last hit be the lowest index. In fixed-priority
    // mode everything lands in hi, giving plain lowest-index priority.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                if (ARB_MODE != 0 && CW'(i) <= r_ptr) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = CW'(i);
                end else begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = CW'(i);
                end
            end
        end
    end

    assign w_found = w_hi_found || w_lo_found;
    assign w_gidx  = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_grant = w_found ? (CHANNELS'(1) << w_gidx) : '0;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CW'(i) == w_gidx)
                w_sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign in_ready = w_load_en ? w_grant : '0;
    assign w_xfer   = w_load_en && w_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= CW'(CHANNELS - 1);  // channel 0 first after reset
        end else if (w_xfer) begin
            r_data  <= w_sel_data;
            r_chan  <= w_gidx;
            r_valid <= 1'b1;
            if (ARB_MODE != 0)
                r_ptr <= w_gidx;
        end else if (out_ready) begin
            // drain with no replacement; data/chan keep last value
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_mux_reg.sv
module tb_rr_mux_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  rr_ready, fp_ready;
    logic [15:0] rr_data, fp_data;
    logic [1:0]  rr_chan, fp_chan;
    logic        rr_valid, fp_valid;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] CH_DATA = {16'hFFFF, 16'h00F0, 16'h0081, 16'h0001};

    always #5 clk = ~clk;

    rr_mux_reg #(.WIDTH(16), .CHANNELS(4), .ARB_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_ready), .out_data(rr_data), .out_chan(rr_chan),
        .out_valid(rr_valid), .out_ready(out_ready)
    );

    rr_mux_reg #(.WIDTH(16), .CHANNELS(4), .ARB_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fp_ready), .out_data(fp_data), .out_chan(fp_chan),
        .out_valid(fp_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  e_rdy;   // in_ready before the edge
        logic        e_vld;   // outputs after the edge
        logic [15:0] e_data;
        logic [1:0]  e_chan;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at negedge, check in_ready mid-cycle, clock, check registered outputs.
    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        in_valid  = v.vld;
        out_ready = v.ordy;
        #1;
        check({tag, " in_ready"}, rr_ready, v.e_rdy);
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, rr_valid, v.e_vld);
        check({tag, " out_data"}, rr_data, v.e_data);
        check({tag, " out_chan"}, rr_chan, v.e_chan);
    endtask

    initial begin
        // vld   ordy  e_rdy   e_vld e_data    e_chan
        tbl[0]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 16'h0081, 2'd1}; // single channel
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0081, 2'd1}; // drains
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'h00F0, 2'd2}; // rr after ptr=1
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'hFFFF, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0}; // wrap
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'h0081, 2'd1};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'h00F0, 2'd2};
        tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0}; // load ch0
        tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'h0001, 2'd0}; // stall x3
        tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'h0001, 2'd0};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'h0001, 2'd0};
        tbl[11] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'h0081, 2'd1}; // drain+load
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 16'h0081, 2'd1};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0081, 2'd1};
        tbl[14] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 16'h00F0, 2'd2};
        tbl[15] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 16'hFFFF, 2'd3}; // ptr=2 -> ch3
        tbl[16] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0}; // ptr=3 -> ch0

        // ---- reset with random inputs
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_data   = {$urandom, $urandom};
            in_valid  = 4'($urandom);
            out_ready = 1'($urandom);
        end
        #1;
        check("rst out_valid", rr_valid, 1'b0);
        check("rst out_data", rr_data, 16'h0000);
        check("rst out_chan", rr_chan, 2'd0);
        check("rst fp out_valid", fp_valid, 1'b0);
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        #1;
        check("rst in_ready", rr_ready, 4'b0001);
        check("rst fp in_ready", fp_ready, 4'b0001);
        in_data  = CH_DATA;
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven vectors
        for (int i = 0; i < 17; i++)
            apply(i, tbl[i]);

        // ---- fixed priority: ch2 always beats ch3
        @(negedge clk);
        in_valid  = 4'b1100;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("fp in_ready 1100", fp_ready, 4'b0100);
            @(posedge clk);
            #1;
            check("fp out_chan 1100", fp_chan, 2'd2);
            check("fp out_data 1100", fp_data, 16'h00F0);
            @(negedge clk);
        end
        in_valid = 4'b1000;
        #1;
        check("fp in_ready ch3", fp_ready, 4'b1000);
        @(posedge clk);
        #1;
        check("fp out_chan ch3", fp_chan, 2'd3);
        check("fp out_data ch3", fp_data, 16'hFFFF);

        // ---- async reset during a stall
        @(negedge clk);
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pre-stall out_valid", rr_valid, 1'b1);
        @(negedge clk);
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", rr_valid, 1'b0);
        check("async rst out_data", rr_data, 16'h0000);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic [1:0]  exp_ch;
            logic [15:0] exp_d;
            logic [63:0] all_d;
            all_d  = CH_DATA;
            exp_ch = 2'(c % 4);
            exp_d  = all_d[exp_ch*16 +: 16];
            #1;
            check("rr restart in_ready", rr_ready, 4'b0001 << exp_ch);
            @(posedge clk);
            #1;
            check("rr restart out_chan", rr_chan, exp_ch);
            check("rr restart out_data", rr_data, exp_d);
            check("rr restart out_valid", rr_valid, 1'b1);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
